// File: rtl/mem_bus_ctrl.sv
// MEM-stage data bus controller: issues one bus transaction per load/store,
// stalls the pipeline while it is outstanding and holds the returned word.
`timescale 1ns/1ps
module mem_bus_ctrl #(
    parameter int KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        except_flag,
    input  logic        stall_other,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall
);

    // state | meaning
    // IDLE  | no access outstanding, waiting for a load/store
    // ADDR  | request on the bus, waiting for address accept
    // DATA  | address accepted, waiting for data/write done
    // HOLD  | access finished but pipeline still held elsewhere
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    localparam bit KSEG_ON = (KSEG_MAP != 0);

    state_t      state, state_nx;
    logic        start, done, kseg;
    logic [31:0] paddr, rdata_q;

    always_comb begin
        kseg  = KSEG_ON && (mem_addr[31:30] == 2'b10);
        paddr = kseg ? {3'b000, mem_addr[28:0]} : mem_addr;
        start = (state == IDLE) && mem_en && !except_flag;
        done  = ((state == DATA) && data_data_ok) ||
                ((state == ADDR) && data_addr_ok && data_data_ok);
    end

    always_comb begin
        state_nx  = state;
        data_req  = 1'b0;
        mem_stall = 1'b0;
        mem_rdata = rdata_q;
        case (state)
            IDLE: begin
                mem_stall = start;
                if (start) state_nx = ADDR;
            end
            ADDR: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
                if (data_addr_ok) state_nx = DATA;
            end
            DATA: begin
                mem_stall = !data_data_ok;
            end
            HOLD: begin
                if (!stall_other) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // completion overrides the ADDR/DATA successor
        if (done) begin
            mem_rdata = data_rdata;
            state_nx  = stall_other ? HOLD : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= 32'h0;
            data_wdata <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state <= state_nx;
            if (start) begin
                data_wr    <= mem_wr;
                data_size  <= mem_size;
                data_addr  <= paddr;
                data_wdata <= mem_wdata;
            end
            if (done) rdata_q <= data_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed and random loads/stores with a
// transaction-level model of latency, address mapping and returned data.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wr, except_flag, stall_other;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        data_req, data_wr, mem_stall;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, mem_rdata;

    logic        n_req, n_wr, n_stall;
    logic [1:0]  n_size;
    logic [31:0] n_addr, n_wdata, n_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.KSEG_MAP(1)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .except_flag(except_flag), .stall_other(stall_other),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    mem_bus_ctrl #(.KSEG_MAP(0)) dut_nomap (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .except_flag(except_flag), .stall_other(stall_other),
        .data_req(n_req), .data_wr(n_wr), .data_size(n_size),
        .data_addr(n_addr), .data_wdata(n_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .mem_rdata(n_rdata), .mem_stall(n_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    // ad: ADDR cycles before accept; dd: cycles from accept to data_ok (0 = same
    // cycle); h: cycles stall_other is high starting at the completion cycle
    task automatic txn(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                       input logic [31:0] wd, input int ad, input int dd,
                       input int h, input logic [31:0] rd);
        int ok_cyc, dok_cyc, exp_stall, stall_cnt, req_cnt;
        logic [31:0] pa;
        pa        = map_addr(a);
        ok_cyc    = ad + 1;
        dok_cyc   = (dd == 0) ? ok_cyc : ok_cyc + dd;
        exp_stall = ad + 2 + ((dd > 1) ? dd - 1 : 0);
        stall_cnt = 0;
        req_cnt   = 0;

        mem_en = 1'b1; mem_wr = wr; mem_size = sz; mem_addr = a; mem_wdata = wd;
        except_flag = 1'b0; stall_other = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
        #2;
        if (mem_stall) stall_cnt++;
        chk("start_req", {31'h0, data_req}, 32'h0);
        chk("start_rdata_held", mem_rdata, last_rd);
        next_cycle();
        // pipeline inputs may wander while stalled; request registers must not
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wr    = ~wr;
        for (int c = 1; c <= dok_cyc; c++) begin
            data_addr_ok = (c == ok_cyc);
            data_data_ok = (c == dok_cyc);
            data_rdata   = (c == dok_cyc) ? rd : $urandom;
            stall_other  = (c == dok_cyc) && (h > 0);
            #2;
            if (mem_stall) stall_cnt++;
            if (data_req) req_cnt++;
            if (c == ok_cyc) begin
                chk("bus_addr", data_addr, pa);
                chk("bus_addr_nomap", n_addr, a);
                chk("bus_wr", {31'h0, data_wr}, {31'h0, wr});
                chk("bus_size", {30'h0, data_size}, {30'h0, sz});
                chk("bus_wdata", data_wdata, wd);
            end
            if (c == dok_cyc) chk("done_rdata", mem_rdata, rd);
            next_cycle();
        end
        data_addr_ok = 1'b0;
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("req_cycles", req_cnt, ad + 1);
        for (int k = 0; k < h; k++) begin
            stall_other  = (k < h - 1);
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            #2;
            chk("hold_req", {31'h0, data_req}, 32'h0);
            chk("hold_stall", {31'h0, mem_stall}, 32'h0);
            chk("hold_rdata", mem_rdata, rd);
            next_cycle();
        end
        mem_en = 1'b0; stall_other = 1'b0;
        data_data_ok = 1'($urandom_range(0, 1));
        data_rdata = $urandom;
        #2;
        chk("idle_req", {31'h0, data_req}, 32'h0);
        chk("idle_stall", {31'h0, mem_stall}, 32'h0);
        chk("idle_rdata", mem_rdata, rd);
        last_rd = rd;
        next_cycle();
        data_data_ok = 1'b0;
    endtask

    initial begin
        logic [31:0] bases [5];
        rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'b00;
        mem_addr = 32'h0; mem_wdata = 32'h0; except_flag = 1'b0; stall_other = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #12;
        chk("rst_req", {31'h0, data_req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // load word through kseg, accept after two waiting ADDR cycles
        txn(32'h8000_1004, 2'b10, 1'b0, 32'h1234_5678, 2, 1, 0, 32'hDEAD_BEEF);
        // store byte, accept and done in the first ADDR cycle
        txn(32'hA000_0003, 2'b00, 1'b1, 32'h3C3C_3C3C, 0, 0, 0, 32'h0000_0000);

        // exception suppresses the access entirely
        mem_en = 1'b1; except_flag = 1'b1; mem_addr = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("exc_req", {31'h0, data_req}, 32'h0);
            chk("exc_stall", {31'h0, mem_stall}, 32'h0);
            next_cycle();
        end
        mem_en = 1'b0; except_flag = 1'b0;
        next_cycle();

        // completion under external stall, mem_en held through HOLD
        txn(32'h0000_2000, 2'b10, 1'b0, 32'h0, 1, 2, 4, 32'hCAFE_F00D);
        // address above kseg window passes through unchanged
        txn(32'hC000_0010, 2'b01, 1'b0, 32'h0, 0, 1, 0, 32'h5555_AAAA);
        txn(32'h8000_0010, 2'b10, 1'b0, 32'h0, 0, 3, 2, 32'h0F0F_0F0F);

        // reset while waiting in DATA abandons the access
        mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h8000_0100;
        next_cycle();
        mem_en = 1'b0; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        #2;
        chk("data_wait_stall", {31'h0, mem_stall}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, data_req}, 32'h0);
        chk("mid_rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("mid_rst_rdata", mem_rdata, 32'h0);
        chk("mid_rst_addr", data_addr, 32'h0);
        next_cycle();
        rst = 1'b0;
        last_rd = 32'h0;
        next_cycle();
        txn(32'h9000_0008, 2'b10, 1'b0, 32'h0, 1, 1, 0, 32'h7777_1111);

        bases[0] = 32'h8000_0000; bases[1] = 32'hA000_0000; bases[2] = 32'h0000_0000;
        bases[3] = 32'hC000_0000; bases[4] = 32'hB000_0000;
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            a = bases[$urandom_range(0, 4)] | ($urandom & 32'h1FFF_FFFF);
            txn(a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
